// File: rtl/bcd_to_bin_seq_pkg.sv
// Shared types and constants for the sequential BCD-to-binary converter.
// Also holds the digit validity helper used when a conversion is requested.
package bcd_conv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int NIBBLE_W    = 4;
  localparam int BCD_MAX     = 9;
  localparam int CORR_THRESH = 8;
  localparam int CORR_SUB    = 3;

  // The helper takes a fixed-width word; callers zero-extend their operand.
  // Zero nibbles are valid, so the padding never causes a rejection.
  localparam int MAX_DIGITS  = 8;
  localparam int BCD_WORD_W  = NIBBLE_W * MAX_DIGITS;

  // Returns 1 when every nibble of the word is a legal decimal digit (0..9).
  function automatic logic bcd_valid(input logic [BCD_WORD_W-1:0] word);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (word[i*NIBBLE_W +: NIBBLE_W] > NIBBLE_W'(BCD_MAX)) begin
        ok = 1'b0;
      end else begin
        ok = ok;
      end
    end
    return ok;
  endfunction

endpackage

// File: rtl/bcd_to_bin_seq_if.sv
// Request/result bundle of the BCD-to-binary converter.
// master = requester (keypad/switch side), slave = converter.
interface bcd_to_bin_seq_if
  import bcd_conv_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
);

  logic                         start;
  logic [NIBBLE_W*DIGITS-1:0]   bcd_in;
  logic                         ready;
  logic                         done;
  logic [BIN_W-1:0]             bin_out;
  logic                         err;

  modport master (
    output start,
    output bcd_in,
    input  ready,
    input  done,
    input  bin_out,
    input  err
  );

  modport slave (
    input  start,
    input  bcd_in,
    output ready,
    output done,
    output bin_out,
    output err
  );

endinterface

// File: rtl/bcd_to_bin_seq_digit_corr.sv
// Per-digit correction of reverse double dabble: after the right shift a
// digit that reached 8 or more carried a half-ten from the digit above,
// so 3 is taken off to bring it back to a legal BCD value.
module bcd_digit_corr
  import bcd_conv_pkg::*;
(
  input  logic [NIBBLE_W-1:0] d,
  output logic [NIBBLE_W-1:0] q
);

  // Conditional subtract of 3 for digits >= 8, otherwise pass through.
  always_comb begin
    q = d;
    if (d >= NIBBLE_W'(CORR_THRESH)) begin
      q = d - NIBBLE_W'(CORR_SUB);
    end else begin
      q = d;
    end
  end

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter (reverse double dabble).
// One shift-and-correct step per clock; BIN_W steps per conversion.
// Operands with a non-decimal nibble are rejected immediately with err=1.
module bcd_to_bin_seq
  import bcd_conv_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
)(
  input  logic               clk,
  input  logic               rst,
  bcd_to_bin_seq_if.slave    bus
);

  localparam int BCD_W = NIBBLE_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  state_e             state_r;
  state_e             state_nx_s;
  logic [BCD_W-1:0]   bcd_r;
  logic [BIN_W-1:0]   bin_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [BIN_W-1:0]   bin_out_r;
  logic               err_r;
  logic               ready_r;
  logic               done_r;

  logic [BCD_WORD_W-1:0] bcd_word_s;
  logic                  valid_s;
  logic [BCD_W-1:0]      bcd_shift_s;
  logic [BCD_W-1:0]      bcd_corr_s;
  logic [BIN_W-1:0]      bin_shift_s;
  logic                  last_step_s;
  logic                  load_s;
  logic                  shift_s;
  logic                  fin_ok_s;
  logic                  fin_err_s;

  // Operand validity is judged on the raw input at the accepting edge.
  assign bcd_word_s = BCD_WORD_W'(bus.bcd_in);
  assign valid_s    = bcd_valid(bcd_word_s);

  // The combined {bcd, bin} register moves right by one: bcd LSB feeds bin MSB.
  assign bcd_shift_s = {1'b0, bcd_r[BCD_W-1:1]};
  assign bin_shift_s = {bcd_r[0], bin_r[BIN_W-1:1]};
  assign last_step_s = (cnt_r == CNT_W'(BIN_W - 1));

  // One correction unit per digit; no borrow crosses digit boundaries.
  for (genvar g = 0; g < DIGITS; g++) begin : g_corr
    bcd_digit_corr u_corr (
      .d (bcd_shift_s[g*NIBBLE_W +: NIBBLE_W]),
      .q (bcd_corr_s[g*NIBBLE_W +: NIBBLE_W])
    );
  end

  // Next-state and datapath control decode.
  always_comb begin
    state_nx_s = state_r;
    load_s     = 1'b0;
    shift_s    = 1'b0;
    fin_ok_s   = 1'b0;
    fin_err_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          if (valid_s) begin
            load_s     = 1'b1;
            state_nx_s = SHIFT;
          end else begin
            fin_err_s  = 1'b1;
            state_nx_s = DONE;
          end
        end else begin
          state_nx_s = IDLE;
        end
      end
      SHIFT: begin
        shift_s = 1'b1;
        if (last_step_s) begin
          fin_ok_s   = 1'b1;
          state_nx_s = DONE;
        end else begin
          state_nx_s = SHIFT;
        end
      end
      DONE: begin
        state_nx_s = IDLE;
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // State register; reset aborts any conversion in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Handshake outputs registered from the next state so they match it exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_r <= 1'b1;
      done_r  <= 1'b0;
    end else begin
      ready_r <= (state_nx_s == IDLE);
      done_r  <= (state_nx_s == DONE);
    end
  end

  // Working shift register and step counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd_r <= {BCD_W{1'b0}};
      bin_r <= {BIN_W{1'b0}};
      cnt_r <= {CNT_W{1'b0}};
    end else if (load_s) begin
      bcd_r <= bus.bcd_in;
      bin_r <= {BIN_W{1'b0}};
      cnt_r <= {CNT_W{1'b0}};
    end else if (shift_s) begin
      bcd_r <= bcd_corr_s;
      bin_r <= bin_shift_s;
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      bcd_r <= bcd_r;
      bin_r <= bin_r;
      cnt_r <= cnt_r;
    end
  end

  // Result registers: updated only on the edge that enters DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_out_r <= {BIN_W{1'b0}};
      err_r     <= 1'b0;
    end else if (fin_ok_s) begin
      bin_out_r <= bin_shift_s;
      err_r     <= 1'b0;
    end else if (fin_err_s) begin
      bin_out_r <= {BIN_W{1'b0}};
      err_r     <= 1'b1;
    end else begin
      bin_out_r <= bin_out_r;
      err_r     <= err_r;
    end
  end

  assign bus.ready   = ready_r;
  assign bus.done    = done_r;
  assign bus.bin_out = bin_out_r;
  assign bus.err     = err_r;

endmodule
